// File: rtl/add_arb.sv
// add_arb: four requesters share one WIDTH-bit adder. A round-robin arbiter picks
//          the winner, and each result is returned with the winner's index.
// Latency: a result is valid two cycles after its accept edge (IDLE -> CALC -> RESP).
//          Accepts are at least three cycles apart.
// Backpressure: the result is held in RESP while rsp_ready is low, and no new request
//          is accepted until the result leaves.
// Ports:   mclk/mreset_n          clock, async active-low reset
//          req_valid/req_ready    per-requester handshake; req_ready is one-hot or zero
//          req_a/req_b            packed operands, requester i at [i*WIDTH +: WIDTH]
//          rsp_valid/rsp_ready    result handshake; rsp_id, rsp_sum (includes carry-out)
//          grant_cnt              accepted-request counter
// Config:  define ADD_ARB_GRANT_CNT_EN to build the grant counter.
//          When the macro is undefined, grant_cnt is tied to 0.
module add_arb #(
   parameter int WIDTH = 16
) (
   input  logic               mclk,
   input  logic               mreset_n,
   input  logic [3:0]         req_valid,
   input  logic [4*WIDTH-1:0] req_a,
   input  logic [4*WIDTH-1:0] req_b,
   output logic [3:0]         req_ready,
   output logic               rsp_valid,
   output logic [1:0]         rsp_id,
   output logic [WIDTH:0]     rsp_sum,
   input  logic               rsp_ready,
   output logic [15:0]        grant_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [1:0]       last_grant;
   logic [1:0]       win_idx;
   logic             win_vld;
   logic             accept;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;

   // Round-robin pick. Offsets are scanned from farthest to nearest, so the requester
   // closest above last_grant is written last and wins. Offset 4 is last_grant itself,
   // which has the lowest priority.
   always_comb begin
      logic [1:0] cand;
      win_vld = 1'b0;
      win_idx = last_grant + 2'd1;
      cand    = 2'd0;
      for (int k = 4; k >= 1; k--) begin
         cand = last_grant + 2'(k);
         if (req_valid[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   // Operand mux for the winner.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < 4; i++) begin
         if (win_idx == 2'(i)) begin
            sel_a = req_a[i*WIDTH +: WIDTH];
            sel_b = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   // req_ready is gated by mreset_n, so it stays low for the whole reset pulse.
   always_comb begin
      req_ready = 4'b0000;
      if (state == IDLE && win_vld && mreset_n)
         req_ready = 4'b0001 << win_idx;
   end

   assign accept    = |req_ready;
   assign rsp_valid = (state == RESP);

   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = accept ? CALC : IDLE;
         CALC:    state_nxt = RESP;
         RESP:    state_nxt = rsp_ready ? IDLE : RESP;
         default: state_nxt = IDLE;   // encoding 2'd3 falls back to IDLE
      endcase
   end

   always_ff @(posedge mclk or negedge mreset_n) begin
      if (!mreset_n) begin
         state      <= IDLE;
         last_grant <= 2'd3;          // makes requester 0 the first choice after reset
         op_a       <= '0;
         op_b       <= '0;
         rsp_id     <= 2'd0;
         rsp_sum    <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_a       <= sel_a;
            op_b       <= sel_b;
            rsp_id     <= win_idx;
            last_grant <= win_idx;
         end
         if (state == CALC)
            rsp_sum <= {1'b0, op_a} + {1'b0, op_b};
      end
   end

`ifdef ADD_ARB_GRANT_CNT_EN
   always_ff @(posedge mclk or negedge mreset_n) begin
      if (!mreset_n)
         grant_cnt <= 16'h0000;
      else if (accept)
         grant_cnt <= grant_cnt + 16'h0001;   // wraps naturally at 16'hFFFF
   end
`else
   assign grant_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_add_arb.sv
module tb_add_arb;

   localparam int W = 16;

   logic           mclk = 1'b0;
   logic           mreset_n = 1'b0;
   logic [3:0]     req_valid = 4'b0000;
   logic [4*W-1:0] req_a = '0;
   logic [4*W-1:0] req_b = '0;
   logic [3:0]     req_ready;
   logic           rsp_valid;
   logic [1:0]     rsp_id;
   logic [W:0]     rsp_sum;
   logic           rsp_ready = 1'b0;
   logic [15:0]    grant_cnt;

   add_arb #(.WIDTH(W)) dut (
      .mclk(mclk), .mreset_n(mreset_n), .req_valid(req_valid), .req_a(req_a),
      .req_b(req_b), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_sum(rsp_sum), .rsp_ready(rsp_ready), .grant_cnt(grant_cnt)
   );

   always #5 mclk = ~mclk;

   int tests = 0;
   int fails = 0;

   // Transaction-level reference: whether a job is in flight, where it is
   // (computing or waiting at the output), and its expected result.
   bit [15:0] a_in [4];
   bit [15:0] b_in [4];
   int        m_last;
   bit        m_busy, m_calc, m_resp;
   int        m_id;
   bit [16:0] m_sum;
   int        m_cnt;
   int        cyc;
   int        grants[$];
   int        grant_cyc[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] exp_cnt();
`ifdef ADD_ARB_GRANT_CNT_EN
      return m_cnt[15:0];
`else
      return 16'h0000;
`endif
   endfunction

   task automatic model_reset();
      m_last = 3; m_busy = 0; m_calc = 0; m_resp = 0; m_id = 0; m_sum = 0; m_cnt = 0;
   endtask

   // Called at a negedge. Asserts reset, checks the reset outputs, and releases
   // reset at the next negedge.
   task automatic do_reset();
      req_valid = 4'b1111;
      mreset_n  = 1'b0;
      #1;
      chk("rst_req_ready", req_ready, 4'b0000);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_id",    rsp_id, 2'd0);
      chk("rst_rsp_sum",   rsp_sum, 17'd0);
      chk("rst_grant_cnt", grant_cnt, 16'd0);
      model_reset();
      @(negedge mclk);
      chk("rst_hold_req_ready", req_ready, 4'b0000);
      mreset_n  = 1'b1;
      req_valid = 4'b0000;
   endtask

   // Drives the inputs for one cycle (starting at a negedge), checks the outputs,
   // and advances the model across the rising edge.
   task automatic run_cycle(input logic [3:0] v, input logic rr);
      int w;
      logic [3:0] exp_rdy;
      req_valid = v;
      rsp_ready = rr;
      for (int i = 0; i < 4; i++) begin
         req_a[i*W +: W] = a_in[i];
         req_b[i*W +: W] = b_in[i];
      end
      #1;
      w = -1;
      if (!m_busy)
         for (int k = 4; k >= 1; k--)
            if (v[(m_last + k) % 4]) w = (m_last + k) % 4;
      exp_rdy = (w >= 0) ? (4'b0001 << w) : 4'b0000;
      chk("req_ready", req_ready, exp_rdy);
      chk("rsp_valid", rsp_valid, m_resp);
      if (m_resp) begin
         chk("rsp_id",  rsp_id, m_id[1:0]);
         chk("rsp_sum", rsp_sum, m_sum);
      end
      chk("grant_cnt", grant_cnt, exp_cnt());
      for (int i = 0; i < 4; i++)
         if (req_ready[i] && v[i]) begin
            grants.push_back(i);
            grant_cyc.push_back(cyc);
         end
      @(posedge mclk);
      if (w >= 0) begin
         m_busy = 1; m_calc = 1; m_id = w; m_last = w; m_cnt++;
         m_sum  = {1'b0, a_in[w]} + {1'b0, b_in[w]};
      end else if (m_calc) begin
         m_calc = 0; m_resp = 1;
      end else if (m_resp && rr) begin
         m_resp = 0; m_busy = 0;
      end
      cyc++;
      @(negedge mclk);
   endtask

   initial begin
      model_reset();
      cyc = 0;
      for (int i = 0; i < 4; i++) begin a_in[i] = 0; b_in[i] = 0; end
      repeat (2) @(negedge mclk);
      do_reset();

      // Single request from requester 2. The result appears two cycles after the accept.
      a_in[2] = 16'h0003; b_in[2] = 16'h0004;
      run_cycle(4'b0100, 1'b1);
      run_cycle(4'b0000, 1'b1);
      chk("single_valid", rsp_valid, 1'b1);
      chk("single_sum", rsp_sum, 17'h00007);
      chk("single_id", rsp_id, 2'd2);
      run_cycle(4'b0000, 1'b1);
      chk("single_one_cycle", rsp_valid, 1'b0);

      // Carry-out from requester 1.
      a_in[1] = 16'hFFFF; b_in[1] = 16'h0001;
      run_cycle(4'b0010, 1'b1);
      run_cycle(4'b0000, 1'b1);
      chk("carry_sum", rsp_sum, 17'h10000);
      run_cycle(4'b0000, 1'b1);

      // Round-robin with all requesters valid from reset.
      do_reset();
      grants.delete(); grant_cyc.delete();
      for (int i = 0; i < 4; i++) begin a_in[i] = 16'(i * 16'h1111); b_in[i] = 16'(i + 1); end
      repeat (13) run_cycle(4'b1111, 1'b1);
      chk("rr_count", grants.size(), 5);
      if (grants.size() == 5) begin
         chk("rr_g0", grants[0], 0);
         chk("rr_g1", grants[1], 1);
         chk("rr_g2", grants[2], 2);
         chk("rr_g3", grants[3], 3);
         chk("rr_g4", grants[4], 0);
         for (int i = 1; i < 5; i++)
            chk("rr_spacing", grant_cyc[i] - grant_cyc[i-1], 3);
      end
      repeat (2) run_cycle(4'b0000, 1'b1);
      chk("cnt_after5", grant_cnt, exp_cnt());
`ifdef ADD_ARB_GRANT_CNT_EN
      chk("cnt_five", grant_cnt, 16'd5);
`else
      chk("cnt_zero", grant_cnt, 16'd0);
`endif

      // Backpressure: the result is held for 5 RESP cycles, then released.
      a_in[3] = 16'h8001; b_in[3] = 16'h7FFF;
      run_cycle(4'b1000, 1'b0);
      run_cycle(4'b1111, 1'b0);
      repeat (5) run_cycle(4'b1111, 1'b0);
      run_cycle(4'b0000, 1'b1);
      chk("bp_idle_again", rsp_valid, 1'b0);
      run_cycle(4'b1111, 1'b1);
      repeat (3) run_cycle(4'b0000, 1'b1);

      // Reset while in CALC: the in-flight result is dropped, and requester 1 wins next.
      run_cycle(4'b0100, 1'b1);
      do_reset();
      repeat (3) begin
         run_cycle(4'b0000, 1'b1);
         chk("abandon_no_rsp", rsp_valid, 1'b0);
      end
      grants.delete(); grant_cyc.delete();
      run_cycle(4'b1010, 1'b1);
      chk("post_rst_grant", (grants.size() == 1) ? grants[0] : -1, 1);
      repeat (3) run_cycle(4'b0000, 1'b1);

      // Random traffic with random backpressure.
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 4; i++) begin
            a_in[i] = 16'($urandom);
            b_in[i] = 16'($urandom);
         end
         run_cycle(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
